// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StAdd  = 2'd1,
    StDone = 2'd2
  } state_e;

endpackage : serial_adder_pkg

// File: rtl/full_adder.sv
// One-bit full adder; purely combinational.
module full_adder (
  input  logic X_i,
  input  logic B_i,
  input  logic C_i,
  output logic S_o,
  output logic C_o
);

  assign S_o = X_i ^ B_i ^ C_i;
  assign C_o = (X_i & B_i) | (C_i & (X_i ^ B_i));

endmodule : full_adder

// File: rtl/serial_adder.sv
// Bit-serial adder: one full_adder evaluation per clock, LSB first, with start/busy/done handshake.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             c_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] sum_o,
  output logic             cout_o
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  state_e           state_q;
  logic [WIDTH-1:0] a_sr_q;
  logic [WIDTH-1:0] b_sr_q;
  logic             carry_q;
  logic [CntW-1:0]  cnt_q;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;

  logic fa_s;
  logic fa_c;

  full_adder u_fa (
    .X_i (a_sr_q[0]),
    .B_i (b_sr_q[0]),
    .C_i (carry_q),
    .S_o (fa_s),
    .C_o (fa_c)
  );

  // Sum bits are shifted into the top of the A register as A bits leave the bottom.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      a_sr_q  <= '0;
      b_sr_q  <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      case (state_q)
        StIdle, StDone: begin
          if (start_i) begin
            a_sr_q  <= a_i;
            b_sr_q  <= b_i;
            carry_q <= c_i;
            cnt_q   <= '0;
            state_q <= StAdd;
          end else begin
            state_q <= StIdle;
          end
        end
        StAdd: begin
          a_sr_q  <= {fa_s, a_sr_q[WIDTH-1:1]};
          b_sr_q  <= {1'b0, b_sr_q[WIDTH-1:1]};
          carry_q <= fa_c;
          cnt_q   <= cnt_q + CntW'(1);
          if (cnt_q == LastCnt) begin
            sum_q   <= {fa_s, a_sr_q[WIDTH-1:1]};
            cout_q  <= fa_c;
            state_q <= StDone;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy_o = (state_q == StAdd);
  assign done_o = (state_q == StDone);
  assign sum_o  = sum_q;
  assign cout_o = cout_q;

endmodule : serial_adder
